cpu5_ifu: RTL and testbench
===========================

# cpu5_ifu

Instruction fetch unit for the cpu5 core: owns the fetch PC, issues single-outstanding requests to instruction memory, buffers returned words in a 2-entry queue, and presents `{pc, inst}` to the decode stage, which slices opcode/funct3/funct7 for the main decoder. Branch/jump redirects flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  core clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_gnt`  in  1  memory accepts request this cycle (when `imem_req`=1).
- `imem_rvalid`  in  1  read data valid; one per granted request, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `id_valid`  out  1  queue head valid.
- `id_inst`  out  32  instruction at queue head.
- `id_pc`  out  32  PC of `id_inst`.
- `id_ready`  in  1  decode consumes head when `id_valid & id_ready`.

## Operation
- Registers: `fetch_pc`, `req_pc` (address of outstanding request), FSM state, 2-entry queue (`{pc, inst}` ×2, rd/wr pointers, 2-bit count 0..2).
- FSM states: REQ, WAIT, DROP.
  - REQ: `imem_req = (count < 2)`, `imem_addr = fetch_pc`. On `imem_req & imem_gnt`: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, go WAIT.
  - WAIT: `imem_req = 0`. On `imem_rvalid`: push `{req_pc, imem_rdata}`, go REQ.
  - DROP: `imem_req = 0`. On `imem_rvalid`: discard data, go REQ.
- `imem_req` depends only on registered state/count (no combinational path from `id_ready` or `imem_gnt`).
- Queue: `id_valid = (count != 0)`. Push and pop in the same cycle leave count unchanged. Count never exceeds 2: a request is issued only when `count < 2`, and its response occupies the reserved slot.
- Redirect (`redirect_valid`=1), highest priority:
  - queue flushed (count 0, pointers 0); `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - REQ without grant: go/stay REQ; new address presented next cycle (request re-addressed; memory must tolerate).
  - REQ with grant same cycle, or WAIT without `imem_rvalid`: go DROP.
  - WAIT with `imem_rvalid` same cycle: data discarded, go REQ.
  - DROP: stay DROP unless `imem_rvalid`, then REQ.
  - A head popped in the redirect cycle counts as consumed.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC + 4 = 32'h0000_0000`.

## Timing
- Reset (async assert): state REQ, `fetch_pc = RESET_PC`, count 0, queue entries 0. Outputs during reset: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_inst`=0, `id_pc`=0.
- First cycle after `resetn` deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Grant at cycle T, `imem_rvalid` at T+1 → `id_valid`=1 at T+2. Next request issued at T+2. Peak throughput: 1 instruction per 2 cycles with 1-cycle memory.
- `imem_addr` holds stable while `imem_req`=1 and `imem_gnt`=0, except on redirect.
- Reset mid-operation: all state cleared immediately; any later `imem_rvalid` before a new grant is ignored (state REQ does not push).

## Test plan
- Reset release, `RESET_PC=32'h100`, memory gnt immediate, rvalid +1, `id_ready`=1 → `id_pc` sequence 0x100, 0x104, 0x108 with matching words, `id_valid` first high 3 cycles after reset release.
- `id_ready`=0 held → exactly 2 entries fill (pc 0x0, 0x4), `imem_req` stays 0 with count 2; raise `id_ready` → 0x0, 0x4, 0x8 delivered in order, none lost or duplicated.
- Redirect to 0x2003 while in WAIT for pc 0x8 → response for 0x8 dropped, queue empty, next `imem_addr` = 0x2000, next `id_pc` = 0x2000.
- Redirect coincident with `imem_gnt` for 0x10 → DROP; response discarded; next request at redirect target; no stale instruction reaches `id_*`.
- Grant stalled 5 cycles → `imem_addr` constant 0x40 throughout; redirect to 0x80 in cycle 3 → `imem_addr` = 0x80 next cycle.
- `RESET_PC=32'hFFFF_FFF8` → `id_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert `resetn`=0 mid-WAIT → outputs at reset values in same cycle, late `imem_rvalid` not pushed.

Source files
------------

// File: rtl/cpu5_ifu_if.sv
//------------------------------------------------------------------------------
// cpu5_ifu_if
//   Bundle of the fetch unit's bus signals: instruction-memory request and
//   response channel, branch/jump redirect, and the decode-side hand-off.
//   Ports (master = fetch unit side):
//     imem_req/imem_addr           out  request valid and word-aligned address
//     imem_gnt                     in   request accepted this cycle
//     imem_rvalid/imem_rdata       in   one response per granted request
//     redirect_valid/redirect_pc   in   flush and refetch from new address
//     id_valid/id_inst/id_pc       out  queue head presented to decode
//     id_ready                     in   decode consumes head
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu5_ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_inst, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_inst, id_pc,
    output id_ready
  );
endinterface

`default_nettype wire

// File: rtl/cpu5_ifu.sv
//------------------------------------------------------------------------------
// cpu5_ifu
//   Instruction fetch unit: owns the fetch PC, issues single-outstanding
//   requests to instruction memory, buffers returned words in a 2-entry queue
//   and presents {pc, inst} to decode. A redirect flushes the queue and
//   discards any response still in flight.
//   Ports:
//     clk     in   core clock
//     resetn  in   asynchronous active-low reset
//     bus     cpu5_ifu_if.master  memory, redirect and decode signals
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu5_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  cpu5_ifu_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q;
  logic        run_q;        // low during reset and the first cycle after it
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_inst_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;

  logic fire;
  logic push;
  logic pop;

  // Request depends on registered state only; count < 2 reserves the slot
  // the outstanding response will occupy.
  assign bus.imem_req  = run_q & (state_q == S_REQ) & (count_q != 2'd2);
  assign bus.imem_addr = fetch_pc_q;

  assign bus.id_valid  = (count_q != 2'd0);
  assign bus.id_inst   = q_inst_q[rd_ptr_q];
  assign bus.id_pc     = q_pc_q[rd_ptr_q];

  assign fire = bus.imem_req & bus.imem_gnt;
  assign push = (state_q == S_WAIT) & bus.imem_rvalid & ~bus.redirect_valid;
  assign pop  = bus.id_valid & bus.id_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Low address bits of a redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      run_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= 32'h0;
      q_pc_q[0]   <= 32'h0;
      q_pc_q[1]   <= 32'h0;
      q_inst_q[0] <= 32'h0;
      q_inst_q[1] <= 32'h0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      run_q <= 1'b1;
      if (bus.redirect_valid) begin
        // A head popped this cycle is simply lost in the flush, which is
        // what "consumed" means for decode.
        fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        count_q    <= 2'd0;
        case (state_q)
          S_REQ:   state_q <= fire ? S_DROP : S_REQ;
          S_WAIT:  state_q <= bus.imem_rvalid ? S_REQ : S_DROP;
          S_DROP:  state_q <= bus.imem_rvalid ? S_REQ : S_DROP;
          default: state_q <= S_REQ;
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (fire) begin
              req_pc_q   <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + 32'd4;
              state_q    <= S_WAIT;
            end
          end
          S_WAIT:  if (bus.imem_rvalid) state_q <= S_REQ;
          S_DROP:  if (bus.imem_rvalid) state_q <= S_REQ;
          default: state_q <= S_REQ;
        endcase
        if (push) begin
          q_pc_q[wr_ptr_q]   <= req_pc_q;
          q_inst_q[wr_ptr_q] <= bus.imem_rdata;
          wr_ptr_q           <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu5_ifu.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cpu5_ifu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; only the selected DUT is out of reset.
  logic [2:0]  rstn;
  logic        gnt, rvalid, redir, rdy;
  logic [31:0] rdata, rpc;
  int          sel;

  cpu5_ifu_if b0 ();
  cpu5_ifu_if b1 ();
  cpu5_ifu_if b2 ();

  cpu5_ifu #(.RESET_PC(32'h0000_0100)) dut0 (.clk(clk), .resetn(rstn[0]), .bus(b0.master));
  cpu5_ifu #(.RESET_PC(32'h0000_0000)) dut1 (.clk(clk), .resetn(rstn[1]), .bus(b1.master));
  cpu5_ifu #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .resetn(rstn[2]), .bus(b2.master));

  assign b0.imem_gnt = gnt;   assign b1.imem_gnt = gnt;   assign b2.imem_gnt = gnt;
  assign b0.imem_rvalid = rvalid; assign b1.imem_rvalid = rvalid; assign b2.imem_rvalid = rvalid;
  assign b0.imem_rdata = rdata; assign b1.imem_rdata = rdata; assign b2.imem_rdata = rdata;
  assign b0.redirect_valid = redir; assign b1.redirect_valid = redir; assign b2.redirect_valid = redir;
  assign b0.redirect_pc = rpc; assign b1.redirect_pc = rpc; assign b2.redirect_pc = rpc;
  assign b0.id_ready = rdy;   assign b1.id_ready = rdy;   assign b2.id_ready = rdy;

  logic        req, ival;
  logic [31:0] addr, ipc, iinst;
  always_comb begin
    req = b0.imem_req; addr = b0.imem_addr; ival = b0.id_valid; ipc = b0.id_pc; iinst = b0.id_inst;
    if (sel == 1) begin
      req = b1.imem_req; addr = b1.imem_addr; ival = b1.id_valid; ipc = b1.id_pc; iinst = b1.id_inst;
    end else if (sel == 2) begin
      req = b2.imem_req; addr = b2.imem_addr; ival = b2.id_valid; ipc = b2.id_pc; iinst = b2.id_inst;
    end
  end

  // Memory model state: one pending response, delivered the cycle after grant
  // unless held.
  logic        pend;
  logic [31:0] pend_addr;
  logic        auto_gnt, hold_rv;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, clock, return after next negedge.
  task automatic cycle();
    logic        g;
    logic [31:0] a;
    gnt    = auto_gnt;
    rvalid = pend && !hold_rv;
    rdata  = rvalid ? word(pend_addr) : 32'h0;
    #1;
    g = req && gnt;
    a = addr;
    @(posedge clk);
    if (rvalid) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    @(negedge clk);
  endtask

  task automatic hold_reset(input int s);
    sel = s; rstn = 3'b000; pend = 1'b0; auto_gnt = 1'b1; hold_rv = 1'b0;
    redir = 1'b0; rpc = 32'h0; rdy = 1'b1;
    cycle();
    cycle();
  endtask

  // Called right after reset release with immediate grant and id_ready=1.
  task automatic stream(input logic [31:0] base, input int n);
    cycle();
    chk("first_req", req, 1);
    chk("first_addr", addr, base);
    chk("ival_c1", ival, 0);
    cycle();
    chk("ival_c2", ival, 0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        cycle();
        chk("ival_gap", ival, 0);
      end
      cycle();
      chk("s_ival", ival, 1);
      chk("s_pc", ipc, base + 32'(4 * k));
      chk("s_inst", iinst, word(base + 32'(4 * k)));
    end
  endtask

  initial begin
    rstn = 3'b000; sel = 0; pend = 1'b0; pend_addr = 32'h0; auto_gnt = 1'b1; hold_rv = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; redir = 1'b0; rpc = 32'h0; rdy = 1'b1;
    @(negedge clk);

    // Reset values and streaming from RESET_PC=0x100
    hold_reset(0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h100);
    chk("rst_ival", ival, 0);
    chk("rst_inst", iinst, 0);
    chk("rst_pc", ipc, 0);
    rstn[0] = 1'b1;
    stream(32'h100, 3);

    // Redirect while waiting for 0x8, with an entry queued
    hold_reset(1);
    rstn[1] = 1'b1;
    cycle(); cycle(); cycle(); cycle(); cycle();   // heads 0x0 consumed, 0x4 queued
    rdy = 1'b0;
    cycle();                                        // grant 0x8, head 0x4 held
    chk("pre_redir_pc", ipc, 32'h4);
    chk("pre_redir_ival", ival, 1);
    redir = 1'b1; rpc = 32'h2003; hold_rv = 1'b1;
    cycle();
    chk("wait_redir_ival", ival, 0);
    chk("drop_req", req, 0);
    redir = 1'b0; hold_rv = 1'b0; rdy = 1'b1;
    cycle();                                        // stale 0x8 response dropped
    chk("after_drop_ival", ival, 0);
    chk("after_drop_req", req, 1);
    chk("after_drop_addr", addr, 32'h2000);
    cycle();
    chk("r1_gap_ival", ival, 0);
    cycle();
    chk("r1_pc", ipc, 32'h2000);
    chk("r1_inst", iinst, word(32'h2000));

    // Redirect in REQ without grant, then redirect coincident with grant of 0x10
    auto_gnt = 1'b0; redir = 1'b1; rpc = 32'h10;
    cycle();
    chk("req_redir_ival", ival, 0);
    chk("req_redir_addr", addr, 32'h10);
    auto_gnt = 1'b1; rpc = 32'h3000;
    cycle();
    chk("gnt_redir_req", req, 0);
    chk("gnt_redir_ival", ival, 0);
    redir = 1'b0;
    cycle();                                        // response for 0x10 discarded
    chk("drop2_ival", ival, 0);
    chk("drop2_addr", addr, 32'h3000);
    cycle();
    chk("drop2_gap_ival", ival, 0);
    cycle();
    chk("r2_pc", ipc, 32'h3000);
    chk("r2_inst", iinst, word(32'h3000));

    // Stalled grant holds address; redirect during the stall re-addresses
    auto_gnt = 1'b0; redir = 1'b1; rpc = 32'h40;
    cycle();
    redir = 1'b0;
    chk("stall_addr0", addr, 32'h40);
    cycle();
    chk("stall_addr1", addr, 32'h40);
    chk("stall_req1", req, 1);
    cycle();
    chk("stall_addr2", addr, 32'h40);
    redir = 1'b1; rpc = 32'h80;
    cycle();
    chk("stall_redir_addr", addr, 32'h80);
    redir = 1'b0; auto_gnt = 1'b1;
    cycle();
    cycle();
    chk("r3_pc", ipc, 32'h80);
    chk("r3_inst", iinst, word(32'h80));

    // Backpressure: exactly two entries fill, then drain in order
    hold_reset(1);
    rdy = 1'b0;
    rstn[1] = 1'b1;
    cycle(); cycle(); cycle(); cycle(); cycle();
    chk("full_req_a", req, 0);
    cycle();
    cycle();
    chk("full_req_b", req, 0);
    chk("full_head_pc", ipc, 32'h0);
    chk("full_head_inst", iinst, word(32'h0));
    rdy = 1'b1;
    cycle();
    chk("drain_pc1", ipc, 32'h4);
    chk("drain_inst1", iinst, word(32'h4));
    chk("drain_req", req, 1);
    chk("drain_addr", addr, 32'h8);
    cycle();
    chk("drain_empty", ival, 0);
    cycle();
    chk("drain_pc2", ipc, 32'h8);
    chk("drain_inst2", iinst, word(32'h8));

    // PC wrap and reset in the middle of WAIT
    hold_reset(2);
    rstn[2] = 1'b1;
    stream(32'hFFFF_FFF8, 3);
    cycle();                                        // grant 0x4, head 0x0 consumed
    hold_rv = 1'b1;
    rstn[2] = 1'b0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_addr", addr, 32'hFFFF_FFF8);
    chk("mid_rst_ival", ival, 0);
    chk("mid_rst_inst", iinst, 0);
    chk("mid_rst_pc", ipc, 0);
    @(negedge clk);
    auto_gnt = 1'b0;
    cycle();
    rstn[2] = 1'b1; hold_rv = 1'b0;
    cycle();                                        // late response arrives in REQ
    chk("late_rv_ival", ival, 0);
    cycle();
    chk("late_rv_ival2", ival, 0);
    chk("late_rv_req", req, 1);
    chk("late_rv_addr", addr, 32'hFFFF_FFF8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
